// File: rtl/adder_inv_pkg.sv
// Shared constants, payload type and difference helper for adder_inv_pipe.
// With ADDER_INV_CHECK_EN defined the payload also carries the out-of-range flag.
package adder_inv_pkg;

    localparam int WIDTH_DEF   = 4;
    localparam int LATENCY_MAX = 8;

    typedef struct packed {
`ifdef ADDER_INV_CHECK_EN
        logic                 err;
`endif
        logic [WIDTH_DEF-1:0] a;
    } adder_inv_payload_t;

    // Two extra bits: the top one marks a negative result, the next one marks >= 2**WIDTH.
    function automatic logic [WIDTH_DEF+1:0] adder_inv_diff(
        input logic [WIDTH_DEF:0]   res,
        input logic [WIDTH_DEF-1:0] b,
        input logic                 ci
    );
        adder_inv_diff = {1'b0, res} - {2'b00, b} - {{(WIDTH_DEF+1){1'b0}}, ci};
    endfunction

endpackage

// File: rtl/adder_inv_stage.sv
// One pipeline slot: a valid bit plus payload, shifted in when advance_i is high.
// Bubbles load a zero payload so idle outputs read as zero.
module adder_inv_stage #(
    parameter int PW = 4
) (
    input  logic          clk,
    input  logic          rst_n,
    input  logic          advance_i,
    input  logic          valid_i,
    input  logic [PW-1:0] payload_i,
    output logic          valid_o,
    output logic [PW-1:0] payload_o
);

    logic          valid_q;
    logic          valid_d;
    logic [PW-1:0] payload_q;
    logic [PW-1:0] payload_d;

    always_comb begin
        valid_d   = valid_q;
        payload_d = payload_q;
        if (advance_i) begin
            valid_d   = valid_i;
            payload_d = valid_i ? payload_i : '0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            valid_q   <= 1'b0;
            payload_q <= '0;
        end else begin
            valid_q   <= valid_d;
            payload_q <= payload_d;
        end
    end

    assign valid_o   = valid_q;
    assign payload_o = payload_q;

endmodule

// File: rtl/adder_inv_pipe.sv
// Recovers operand a = {co,sum} - b - ci through a fixed-latency, globally stalled pipeline.
// Optional feature macro ADDER_INV_CHECK_EN adds the err output for unreachable results.
module adder_inv_pipe
    import adder_inv_pkg::*;
#(
    parameter int WIDTH   = WIDTH_DEF,
    parameter int LATENCY = 3
) (
    input  logic             clk,
    input  logic             rst_n,
    input  logic             in_valid,
    output logic             in_ready,
    input  logic [WIDTH:0]   res,
    input  logic [WIDTH-1:0] b,
    input  logic             ci,
    output logic             out_valid,
    input  logic             out_ready,
    output logic [WIDTH-1:0] a,
`ifdef ADDER_INV_CHECK_EN
    output logic             err,
`endif
    output logic [15:0]      done_cnt
);

    localparam int DW = WIDTH + 2;
`ifdef ADDER_INV_CHECK_EN
    localparam int PW = WIDTH + 1;
`else
    localparam int PW = WIDTH;
`endif

    logic [DW-1:0]            diff;
    logic [PW-1:0]            pay_in;
    logic                     advance;
    logic [LATENCY:0]         valid_s;
    logic [LATENCY:0][PW-1:0] pay_s;
    logic [15:0]              done_cnt_q;
    logic [15:0]              done_cnt_d;

    if (WIDTH == WIDTH_DEF) begin : g_diff_pkg
        assign diff = adder_inv_diff(res, b, ci);
    end else begin : g_diff_gen
        assign diff = {1'b0, res} - {2'b00, b} - {{(DW-1){1'b0}}, ci};
    end

`ifdef ADDER_INV_CHECK_EN
    assign pay_in = {|diff[DW-1:WIDTH], WIDTH'(diff)};
`else
    assign pay_in = WIDTH'(diff);
`endif

    // Valid/ready: a transfer happens on an edge where valid && ready; the whole
    // pipeline shifts whenever the last slot is empty or is being drained.
    assign advance    = out_ready || !out_valid;
    assign in_ready   = advance;
    assign valid_s[0] = in_valid;
    assign pay_s[0]   = pay_in;

    for (genvar i = 0; i < LATENCY; i++) begin : g_stage
        adder_inv_stage #(.PW(PW)) u_stage (
            .clk       (clk),
            .rst_n     (rst_n),
            .advance_i (advance),
            .valid_i   (valid_s[i]),
            .payload_i (pay_s[i]),
            .valid_o   (valid_s[i+1]),
            .payload_o (pay_s[i+1])
        );
    end

    assign out_valid = valid_s[LATENCY];
    assign a         = pay_s[LATENCY][WIDTH-1:0];
`ifdef ADDER_INV_CHECK_EN
    assign err       = pay_s[LATENCY][WIDTH];
`endif

    assign done_cnt_d = (out_valid && out_ready) ? done_cnt_q + 16'd1 : done_cnt_q;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            done_cnt_q <= '0;
        end else begin
            done_cnt_q <= done_cnt_d;
        end
    end

    assign done_cnt = done_cnt_q;

endmodule

// File: tb/tb_adder_inv_pipe.sv
// Directed bench for adder_inv_pipe (LATENCY=3, WIDTH=4); err checks appear when
// ADDER_INV_CHECK_EN is defined.
module tb_adder_inv_pipe;

  logic        clk;
  logic        rst_n;
  logic        in_valid;
  logic        in_ready;
  logic [4:0]  res;
  logic [3:0]  b;
  logic        ci;
  logic        out_valid;
  logic        out_ready;
  logic [3:0]  a;
`ifdef ADDER_INV_CHECK_EN
  logic        err;
`endif
  logic [15:0] done_cnt;

  int errors = 0;
  int checks = 0;
  logic [4:0] exp_q[$];

  adder_inv_pipe #(.WIDTH(4), .LATENCY(3)) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .in_valid  (in_valid),
    .in_ready  (in_ready),
    .res       (res),
    .b         (b),
    .ci        (ci),
    .out_valid (out_valid),
    .out_ready (out_ready),
    .a         (a),
`ifdef ADDER_INV_CHECK_EN
    .err       (err),
`endif
    .done_cnt  (done_cnt)
  );

  // clock / reset
  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Independent integer model: {range_err, low 4 bits}
  function automatic logic [4:0] model(input int r, input int bb, input int c);
    int d;
    d = r - bb - c;
    model = {(d < 0 || d > 15), 4'(d & 15)};
  endfunction

  task automatic compare_out(input string tag, input logic [4:0] exp);
    check({tag, "_a"}, 32'(a), 32'(exp[3:0]));
`ifdef ADDER_INV_CHECK_EN
    check({tag, "_err"}, 32'(err), 32'(exp[4]));
`endif
  endtask

  task automatic drive(input int r, input int bb, input int c);
    res      = 5'(r);
    b        = 4'(bb);
    ci       = 1'(c);
    in_valid = 1'b1;
  endtask

  // Send one item into an empty pipeline and wait (bounded) for its output.
  task automatic single(input string tag, input int r, input int bb, input int c,
                        input logic [4:0] exp);
    logic got;
    out_ready = 1'b1;
    drive(r, bb, c);
    tick;
    in_valid = 1'b0;
    got = 1'b0;
    for (int k = 0; k < 10 && !got; k++) begin
      if (out_valid) got = 1'b1;
      else tick;
    end
    check({tag, "_seen"}, 32'(got), 32'd1);
    if (got) compare_out(tag, exp);
    tick;
  endtask

  int v_res[8] = '{0, 31, 16, 7, 10, 25, 1, 30};
  int v_b[8]   = '{0, 15,  0, 3, 10, 12, 0, 14};
  int v_ci[8]  = '{0,  1,  0, 1,  1,  0, 1,  1};

  initial begin
    int  last;
    int  n_out;
    int  stale;
    int  xfers;
    logic ffff_seen;
    logic [4:0] e;

    rst_n     = 1'b0;
    in_valid  = 1'b0;
    out_ready = 1'b0;
    res       = '0;
    b         = '0;
    ci        = 1'b0;

    // reset state
    tick;
    tick;
    check("rst_out_valid", 32'(out_valid), 32'd0);
    check("rst_a", 32'(a), 32'd0);
    check("rst_done_cnt", 32'(done_cnt), 32'd0);
`ifdef ADDER_INV_CHECK_EN
    check("rst_err", 32'(err), 32'd0);
`endif
    rst_n = 1'b1;
    tick;
    check("rst_in_ready", 32'(in_ready), 32'd1);

    // single transfer: presented after edge 0, sampled by edge 1, valid after edge 3
    out_ready = 1'b1;
    drive(19, 9, 1);
    tick;
    in_valid = 1'b0;
    check("lat_e1_valid", 32'(out_valid), 32'd0);
    tick;
    check("lat_e2_valid", 32'(out_valid), 32'd0);
    tick;
    check("lat_e3_valid", 32'(out_valid), 32'd1);
    compare_out("lat_e3", 5'b0_1001);
    check("lat_e3_done", 32'(done_cnt), 32'd0);
    tick;
    check("lat_e4_done", 32'(done_cnt), 32'd1);
    check("lat_e4_valid", 32'(out_valid), 32'd0);

    // range boundaries
    single("neg_err",  0,  1, 0, 5'b1_1111);
    single("big_err",  31, 0, 0, 5'b1_1111);
    single("eq16_err", 16, 0, 0, 5'b1_0000);
    single("max_ok",   31, 15, 1, 5'b0_1111);
    single("zero_ok",  0,  0, 0, 5'b0_0000);

    // back-to-back: 8 transfers, outputs on consecutive cycles
    exp_q = {};
    out_ready = 1'b1;
    last  = -1;
    n_out = 0;
    for (int c = 0; c < 16; c++) begin
      if (c < 8) begin
        drive(v_res[c], v_b[c], v_ci[c]);
        exp_q.push_back(model(v_res[c], v_b[c], v_ci[c]));
      end else begin
        in_valid = 1'b0;
      end
      tick;
      if (out_valid) begin
        if (exp_q.size() > 0) begin
          e = exp_q.pop_front();
          compare_out($sformatf("b2b_%0d", n_out), e);
        end
        if (last >= 0) check("b2b_consecutive", 32'(c), 32'(last + 1));
        last = c;
        n_out++;
      end
    end
    check("b2b_count", 32'(n_out), 32'd8);
    check("b2b_queue_empty", 32'(exp_q.size()), 32'd0);

    // backpressure: fill with out_ready low, stall 5 cycles, then drain
    exp_q = {};
    out_ready = 1'b0;
    for (int c = 0; c < 3; c++) begin
      drive(v_res[c + 3], v_b[c + 3], v_ci[c + 3]);
      exp_q.push_back(model(v_res[c + 3], v_b[c + 3], v_ci[c + 3]));
      tick;
    end
    in_valid = 1'b0;
    for (int k = 0; k < 5; k++) begin
      res = 5'(k * 7 + 3);
      b   = 4'(k + 5);
      ci  = 1'(k);
      check("stall_in_ready", 32'(in_ready), 32'd0);
      check("stall_out_valid", 32'(out_valid), 32'd1);
      compare_out("stall_hold", exp_q[0]);
      tick;
    end
    out_ready = 1'b1;
    #1;
    check("release_in_ready", 32'(in_ready), 32'd1);
    n_out = 0;
    for (int k = 0; k < 12 && exp_q.size() > 0; k++) begin
      if (out_valid) begin
        e = exp_q.pop_front();
        compare_out($sformatf("drain_%0d", n_out), e);
        n_out++;
      end
      tick;
    end
    check("drain_count", 32'(n_out), 32'd3);
    check("drain_no_dup", 32'(out_valid), 32'd0);

    // reset with two transactions in flight, one of them already at the output
    out_ready = 1'b1;
    drive(20, 3, 0);
    tick;
    drive(2, 5, 1);
    tick;
    in_valid = 1'b0;
    tick;
    out_ready = 1'b0;
    check("pre_rst_valid", 32'(out_valid), 32'd1);
    compare_out("pre_rst", 5'b1_0001);
    #2;
    rst_n = 1'b0;
    #1;
    check("mid_rst_valid", 32'(out_valid), 32'd0);
    check("mid_rst_a", 32'(a), 32'd0);
    check("mid_rst_done", 32'(done_cnt), 32'd0);
`ifdef ADDER_INV_CHECK_EN
    check("mid_rst_err", 32'(err), 32'd0);
`endif
    tick;
    tick;
    rst_n     = 1'b1;
    out_ready = 1'b1;
    stale = 0;
    for (int k = 0; k < 6; k++) begin
      tick;
      if (out_valid) stale++;
    end
    check("post_rst_stale", 32'(stale), 32'd0);
    check("post_rst_in_ready", 32'(in_ready), 32'd1);
    check("post_rst_done", 32'(done_cnt), 32'd0);

    // done_cnt wrap after 65536 transfers
    xfers     = 0;
    ffff_seen = 1'b0;
    for (int c = 0; c < 65536 + 20 && xfers < 65536; c++) begin
      if (c < 65536) drive(c & 31, (c >> 5) & 15, (c >> 9) & 1);
      else in_valid = 1'b0;
      if (out_valid && out_ready) xfers++;
      tick;
      if (xfers == 65535 && !ffff_seen) begin
        ffff_seen = 1'b1;
        check("wrap_ffff", 32'(done_cnt), 32'h0000_FFFF);
      end
    end
    in_valid = 1'b0;
    check("wrap_xfers", 32'(xfers), 32'd65536);
    check("wrap_zero", 32'(done_cnt), 32'd0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/adder_inv_pipe.md
# adder_inv_pipe

- Clocked inverse of the 4-bit ripple adder: takes an adder result `{co,sum}` plus the addend `b` and carry-in `ci`, and recovers operand `a = {co,sum} − b − ci`.
- The adder's propagation delay is replaced by a fixed, cycle-accurate pipeline latency with a valid/ready handshake. Every accepted input is evaluated; none is dropped.
- Sits on the consumer side of the adder result bus. It acts as a self-check decoder in the arithmetic datapath and the test harness.

## Interface
- `WIDTH`, 4: operand width; the result bus is `WIDTH+1` bits.
- `LATENCY`, 3: cycles from input acceptance to output valid; legal range 1..8.
- `clk` in 1: single clock, rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `in_valid` in 1: input transaction present.
- `in_ready` out 1: block can accept this cycle.
- `res` in `WIDTH+1`: adder result, `{co,sum}`, with `co` in the MSB.
- `b` in `WIDTH`: addend used by the adder.
- `ci` in 1: carry-in used by the adder.
- `out_valid` out 1: recovered operand present.
- `out_ready` in 1: downstream accepts.
- `a` out `WIDTH`: recovered operand.
- `err` out 1: result not producible by a `WIDTH`-bit `a` (present only with the check feature; see Configuration).
- `done_cnt` out 16: count of completed output transfers.

## Operation
- A transfer occurs when `in_valid && in_ready`. On that clock edge the input is written to stage 0.
- Arithmetic is evaluated on the input side, before stage 0:
  - `diff = res − b − ci`, computed in `WIDTH+2` bits signed (zero-extend all operands).
  - `a = diff[WIDTH−1:0]`.
  - `diff` is out of range when `diff < 0` or `diff ≥ 2**WIDTH`.
- The pipeline has `LATENCY` stages. Each stage holds a valid bit plus its payload (`a`, and `err` when configured).
- Advancement is a global stall:
  - `advance = out_ready || !out_valid`.
  - `in_ready = advance`.
  - When `advance` is high, every stage shifts by one. A stage with no input transfer loads valid=0 (a bubble).
  - When `advance` is low, every stage holds.
- Bubbles are not compressed; throughput is 1 per cycle when no stall is present.
- `out_valid`, `a` and `err` are driven directly from the last stage's registers (no combinational path from inputs).
- `done_cnt` increments on each `out_valid && out_ready` and wraps from 16'hFFFF to 0.
- Reset (asynchronous, any time, including mid-transaction):
  - All stage valid bits = 0; payload = 0; `done_cnt` = 0.
  - Therefore `out_valid`=0, `a`=0, `err`=0.
  - `in_ready` = 1 one cycle after reset deassertion, because it follows `advance` with `out_valid`=0.
  - In-flight transactions are discarded, not completed.
- Simultaneous accept and output transfer in one cycle is legal; the pipeline shifts once.
- Inputs are sampled only on transfer. Changes to `res`/`b`/`ci` while `in_valid` is low, or during a stall, have no effect.

## Timing
- An input accepted at edge N appears with `out_valid`=1 after edge N+`LATENCY`, assuming no stalls.
- Each stall cycle adds one cycle of latency to every in-flight transaction.
- `in_ready` depends combinationally on `out_ready`. This is the only combinational input-to-output path.
- `out_valid`/`a`/`err` stay stable while `out_valid && !out_ready`.

## Configuration
- Macro: `ADDER_INV_CHECK_EN`.
- Defined:
  - The `err` port exists.
  - Each stage carries the range flag.
  - `err` = 1 alongside the corresponding `a` when `diff` is out of range; `a` is still the truncated low bits.
- Undefined:
  - The `err` port and its flag registers are absent.
  - `a` is the truncated result with no indication.
  - All other behaviour is identical.

## Structure
- Package `adder_inv_pkg` holds:
  - `WIDTH_DEF`=4 and `LATENCY_MAX`=8.
  - Typedef `adder_inv_payload_t`, a packed struct of `a` plus `err` under the macro.
  - A function `adder_inv_diff`, returning `WIDTH+2`-bit `diff`.
- One sub-module, `adder_inv_stage`:
  - A single valid+payload register with async reset and an `advance` enable.
  - The top instantiates `LATENCY` of them in a generate loop.

## Test plan
- Reset then single transfer, `LATENCY`=3: `res`=5'b1_0011, `b`=9, `ci`=1 at edge 0.
  - Required: `out_valid`=1 after edge 3, `a`=9, `err`=0, `done_cnt`=1 after the transfer.
- Range error (`ADDER_INV_CHECK_EN` defined): `res`=0, `b`=1, `ci`=0.
  - Required: `a`=4'hF, `err`=1.
- Second range error: `res`=5'h1F, `b`=0, `ci`=0.
  - Required: `a`=4'hF, `err`=1.
- Back-to-back: 8 consecutive transfers with `out_ready`=1.
  - Required: 8 outputs on 8 consecutive cycles, in order, values matching the model.
- Backpressure: hold `out_ready`=0 for 5 cycles with the pipeline full.
  - Required: `in_ready`=0, outputs stable; after release, no loss and no duplication.
- Reset mid-flight: assert `rst_n`=0 with 2 transactions in flight.
  - Required: outputs and `done_cnt` go to 0 immediately; no stale `out_valid` appears after release.
- `done_cnt` wrap: preload via 65 536 transfers.
  - Required: reads 0 after the last transfer.
